ir_nec_tx: RTL

// - NEC-format infrared transmitter; transmit-side counterpart of the IR1498 receiver path in the kernel system.
// - Accepts an 8-bit address + 8-bit command via valid/ready and serialises an NEC frame:

---
 rtl/ir_nec_tx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises leader, 32 data bits LSB-first {~cmd,cmd,~addr,addr} and a stop mark.
// Define IR_NEC_TX_REPEAT_EN to add the tx_repeat port and the short repeat-code frame.
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439,
    parameter int GAP_UNITS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
`ifdef IR_NEC_TX_REPEAT_EN
    input  logic       tx_repeat,
`endif
    output logic       ir_env,
    output logic       ir_out,
    output logic       busy,
    output logic       done
);

    localparam int CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int KW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int MAX_UNIT = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int UW       = $clog2(MAX_UNIT + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_MARK  = 3'd1;
    localparam logic [2:0] LEAD_SPACE = 3'd2;
    localparam logic [2:0] BIT_MARK   = 3'd3;
    localparam logic [2:0] BIT_SPACE  = 3'd4;
    localparam logic [2:0] STOP_MARK  = 3'd5;
    localparam logic [2:0] GAP        = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cyc_cnt;
    logic [UW-1:0] unit_cnt;
    logic [UW-1:0] unit_len;
    logic [KW-1:0] car_cnt;
    logic [31:0]   shreg;
    logic [4:0]    bit_idx;
    logic          rpt_q;
    logic          unit_end;
    logic          state_end;
    logic          is_mark;

    // Length of the current state in NEC units; bit spaces depend on the bit being sent.
    always_comb begin
        unit_len = UW'(1);
        case (state)
            LEAD_MARK:  unit_len = UW'(16);
            LEAD_SPACE: unit_len = rpt_q ? UW'(4) : UW'(8);
            BIT_SPACE:  unit_len = shreg[0] ? UW'(3) : UW'(1);
            GAP:        unit_len = UW'(GAP_UNITS);
            default:    unit_len = UW'(1);
        endcase
    end

    assign unit_end  = (cyc_cnt == CW'(UNIT_CYCLES - 1));
    assign state_end = unit_end && (unit_cnt == unit_len - UW'(1));
    assign is_mark   = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    assign tx_ready  = (state == IDLE);
    assign busy      = ~tx_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            car_cnt  <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            rpt_q    <= 1'b0;
            ir_env   <= 1'b0;
            ir_out   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            ir_env  <= is_mark;
            ir_out  <= is_mark && (car_cnt < KW'(CARRIER_HIGH));
            car_cnt <= (car_cnt == KW'(CARRIER_DIV - 1)) ? '0 : car_cnt + KW'(1);

            if (state == IDLE) begin
                cyc_cnt  <= '0;
                unit_cnt <= '0;
                if (tx_valid) begin
                    shreg   <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                    bit_idx <= '0;
`ifdef IR_NEC_TX_REPEAT_EN
                    rpt_q   <= tx_repeat;
`else
                    rpt_q   <= 1'b0;
`endif
                    car_cnt <= '0;
                    state   <= LEAD_MARK;
                end
            end else if (state_end) begin
                cyc_cnt  <= '0;
                unit_cnt <= '0;
                case (state)
                    LEAD_MARK: state <= LEAD_SPACE;
                    LEAD_SPACE: begin
                        car_cnt <= '0;
                        state   <= rpt_q ? STOP_MARK : BIT_MARK;
                    end
                    BIT_MARK: state <= BIT_SPACE;
                    BIT_SPACE: begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 5'd1;
                        car_cnt <= '0;
                        state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                    STOP_MARK: state <= GAP;
                    GAP: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                cyc_cnt <= unit_end ? '0 : cyc_cnt + CW'(1);
                if (unit_end)
                    unit_cnt <= unit_cnt + UW'(1);
            end
        end
    end

endmodule
